spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 7, register bus address width; legal range 1..7.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 frame_abort  input  1  high while SPI chip select is inactive; level-sensitive.
REQ-005 rx_data  input  8  byte from SPI RX FIFO.
REQ-006 rx_empty  input  1  RX FIFO empty.
REQ-007 rx_rd_en  output  1  one-cycle RX FIFO pop.
REQ-008 tx_data  output  8  byte to SPI TX FIFO.
REQ-009 tx_wr_en  output  1  one-cycle TX FIFO push.
REQ-010 tx_full  input  1  TX FIFO full.
REQ-011 bus_addr  output  ADDR_W  register bus address.
REQ-012 bus_we / bus_re  output  1 each  one-cycle write / read strobes; never both high.
REQ-013 bus_wdata  output  8  write data; bus_rdata  input  8  read data, valid the cycle after bus_re.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Frame format: byte0 = command {rw, addr[6:0]} (rw=1 write, rw=0 read); byte1 = length L; then L+1 data transfers (1..256).
REQ-016 Address = cmd[ADDR_W-1:0]; bits above ADDR_W ignored; increments after each transfer, wrapping modulo 2^ADDR_W.
REQ-017 RX pop: rx_rd_en asserted only when rx_empty=0 in a byte-consuming state; rx_data sampled the cycle after rx_rd_en; at most one pop in flight.
REQ-018 States: IDLE, GET_CMD, GET_LEN, GET_WDATA, BUS_WR, BUS_RD, WAIT_RD, PUSH_TX.
REQ-019 IDLE -> GET_CMD when rx_empty=0 and frame_abort=0; GET_CMD -> GET_LEN on command byte; GET_LEN -> GET_WDATA (rw=1) or BUS_RD (rw=0).
REQ-020 Write: GET_WDATA -> BUS_WR on data byte; BUS_WR drives bus_we=1, bus_addr, bus_wdata for exactly one cycle; then GET_WDATA, or IDLE after the last transfer.
REQ-021 Read: BUS_RD pulses bus_re one cycle; WAIT_RD captures bus_rdata; PUSH_TX holds until tx_full=0, then pulses tx_wr_en with captured byte; then BUS_RD, or IDLE after the last transfer.
REQ-022 Read data bytes shall not be consumed from RX; bytes clocked in by the master during a read phase stay in RX FIFO and are discarded at the next IDLE entry from an abort.
REQ-023 tx_wr_en never asserted while tx_full=1; no TX byte lost or duplicated.
REQ-024 frame_abort=1 in any state: next cycle state = IDLE, all strobes low; a bus_we/bus_re already asserted that cycle completes; no partial write issued afterwards.
REQ-025 While in IDLE with frame_abort=1 and rx_empty=0, block pops and drops RX bytes (flush), one per two cycles.
REQ-026 Transfer counter 8 bits, loaded with L, decremented per transfer; last transfer when counter=0 before decrement.
REQ-027 Per-byte write throughput: one bus_we per RX byte, minimum 3 cycles per byte (pop, sample, write).

Reset
REQ-028 On rst: state IDLE; rx_rd_en, tx_wr_en, bus_we, bus_re, busy = 0; bus_addr, bus_wdata, tx_data, counter, captured read byte = 0.
REQ-029 rst asserted mid-frame aborts immediately with no further bus or FIFO strobes; bytes pending in FIFOs are not touched by this block.

Structure
REQ-030 Shared package holds state enum encoding, command bit positions (RW_BIT=7), and LEN_W=8.
REQ-031 Single module, no sub-modules; FIFOs and register bank external.

Verification
REQ-032 Write burst: RX = 0x85,0x01,0xAA,0xBB -> bus_we at addr 0x05 data 0xAA, then addr 0x06 data 0xBB; IDLE after.
REQ-033 Read single: RX = 0x10,0x00, bus_rdata=0x3C at addr 0x10 -> exactly one tx_wr_en with tx_data=0x3C.
REQ-034 Wrap: ADDR_W=7, RX = 0xFF,0x01,0x11,0x22 -> writes at 0x7F then 0x00.
REQ-035 Backpressure: read L=2 with tx_full held high 10 cycles -> PUSH_TX stalls, tx_wr_en low, then 3 pushes in order, none lost.
REQ-036 Abort: frame_abort asserted after first data byte of L=3 write -> exactly one bus_we, IDLE next cycle, remaining RX bytes flushed.
REQ-037 Reset mid-read during WAIT_RD -> all outputs 0 next cycle, no tx_wr_en.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge_pkg
//
// Shared definitions for the SPI-to-register-bus bridge:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - command byte layout (RW_BIT marks a write when set)
//   - transfer-length field width
//   - is_rx_state(): true for the states that consume bytes from the RX FIFO
// -----------------------------------------------------------------------------
package spi_reg_bridge_pkg;

  // Command byte is {rw, addr[6:0]}; rw = 1 selects a write burst.
  localparam int RW_BIT = 7;

  // Length byte and transfer counter width.
  localparam int LEN_W = 8;

  // FSM state encoding.
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_GET_CMD   = 3'd1;
  localparam logic [ST_W-1:0] ST_GET_LEN   = 3'd2;
  localparam logic [ST_W-1:0] ST_GET_WDATA = 3'd3;
  localparam logic [ST_W-1:0] ST_BUS_WR    = 3'd4;
  localparam logic [ST_W-1:0] ST_BUS_RD    = 3'd5;
  localparam logic [ST_W-1:0] ST_WAIT_RD   = 3'd6;
  localparam logic [ST_W-1:0] ST_PUSH_TX   = 3'd7;

  // States in which the bridge pops and samples a byte from the RX FIFO.
  function automatic logic is_rx_state(input logic [ST_W-1:0] st);
    return (st == ST_GET_CMD) || (st == ST_GET_LEN) || (st == ST_GET_WDATA);
  endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
//
// Turns a byte stream from an SPI slave's RX FIFO into register-bus accesses.
// Frame: byte0 = {rw, addr}, byte1 = length L, then L+1 data transfers.
//   Write (rw=1): each following RX byte becomes one bus_we at an incrementing
//                 address.
//   Read  (rw=0): each transfer issues bus_re, captures bus_rdata on the next
//                 cycle and pushes it to the TX FIFO. RX bytes that arrive
//                 during a read are left in the RX FIFO.
// The address wraps modulo 2^ADDR_W. While frame_abort is high the bridge
// returns to IDLE and drains the RX FIFO at one byte every two cycles.
//
// Ports
//   clk          in   system clock (rising edge)
//   rst          in   asynchronous, active-high reset
//   frame_abort  in   high while SPI chip select is inactive
//   rx_data      in   [7:0] RX FIFO read data (valid the cycle after rx_rd_en)
//   rx_empty     in   RX FIFO empty
//   rx_rd_en     out  one-cycle RX FIFO pop
//   tx_data      out  [7:0] TX FIFO write data
//   tx_wr_en     out  one-cycle TX FIFO push
//   tx_full      in   TX FIFO full
//   bus_addr     out  [ADDR_W-1:0] register bus address
//   bus_we       out  one-cycle write strobe
//   bus_re       out  one-cycle read strobe
//   bus_wdata    out  [7:0] register write data
//   bus_rdata    in   [7:0] register read data (valid the cycle after bus_re)
//   busy         out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_re,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  output logic              busy
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [ST_W-1:0]   r_state;
  logic              r_rw;        // latched command direction
  logic              r_pending;   // a pop was issued last cycle; rx_data is valid now
  logic              r_flush_ph;  // alternates so flush pops happen every other cycle
  logic [LEN_W-1:0]  r_cnt;       // transfers remaining after the current one
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;     // byte captured from bus_rdata, pushed to TX

  logic              w_rx_pop;
  logic              w_tx_push;
  logic              w_last;

  assign w_last = (r_cnt == '0);

  // ---------------------------------------------------------------------------
  // FIFO strobes
  //
  // Pops in a byte-consuming state wait until the previously popped byte has
  // been sampled, so at most one pop is ever in flight. Flush pops only happen
  // in IDLE with frame_abort high and are spaced by r_flush_ph; because that
  // register is cleared on entry to IDLE, the first IDLE cycle after an abort
  // never pops. Both FIFO strobes are suppressed in any cycle where
  // frame_abort is high, except for flush pops.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rx_pop  = 1'b0;
    w_tx_push = 1'b0;
    if (!frame_abort) begin
      if (is_rx_state(r_state)) begin
        w_rx_pop = !rx_empty && !r_pending;
      end
      w_tx_push = (r_state == ST_PUSH_TX) && !tx_full;
    end else if (r_state == ST_IDLE) begin
      w_rx_pop = !rx_empty && r_flush_ph;
    end
  end

  assign rx_rd_en  = w_rx_pop;
  assign tx_wr_en  = w_tx_push;
  assign tx_data   = r_rdata;

  // Bus strobes are pure state decodes, so a strobe that is already high
  // when frame_abort rises still completes in that cycle.
  assign bus_we    = (r_state == ST_BUS_WR);
  assign bus_re    = (r_state == ST_BUS_RD);
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge, regardless of the
  // order of the statements below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rw       <= 1'b0;
      r_pending  <= 1'b0;
      r_flush_ph <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      // Only pops made by a byte-consuming state are followed by a sample;
      // flush pops simply discard the byte.
      r_pending <= w_rx_pop && is_rx_state(r_state);

      if (frame_abort) begin
        r_state    <= ST_IDLE;
        r_flush_ph <= (r_state == ST_IDLE) && !rx_empty && !r_flush_ph;
      end else begin
        r_flush_ph <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (!rx_empty) begin
              r_state <= ST_GET_CMD;
            end
          end

          ST_GET_CMD: begin
            if (r_pending) begin
              // Command bits above the bus address width are ignored.
              r_addr  <= rx_data[ADDR_W-1:0];
              r_rw    <= rx_data[RW_BIT];
              r_state <= ST_GET_LEN;
            end
          end

          ST_GET_LEN: begin
            if (r_pending) begin
              r_cnt   <= rx_data;
              r_state <= r_rw ? ST_GET_WDATA : ST_BUS_RD;
            end
          end

          ST_GET_WDATA: begin
            if (r_pending) begin
              r_wdata <= rx_data;
              r_state <= ST_BUS_WR;
            end
          end

          ST_BUS_WR: begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt - LEN_W'(1);
              r_state <= ST_GET_WDATA;
            end
          end

          ST_BUS_RD: begin
            r_state <= ST_WAIT_RD;
          end

          ST_WAIT_RD: begin
            r_rdata <= bus_rdata;
            r_state <= ST_PUSH_TX;
          end

          ST_PUSH_TX: begin
            // Hold the captured byte until the TX FIFO has room.
            if (!tx_full) begin
              r_addr <= r_addr + ADDR_W'(1);
              if (w_last) begin
                r_state <= ST_IDLE;
              end else begin
                r_cnt   <= r_cnt - LEN_W'(1);
                r_state <= ST_BUS_RD;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
//
// Bench for spi_reg_bridge (ADDR_W = 7). Behavioural models of the RX FIFO,
// TX FIFO and a 128-byte register bank surround the DUT. A table of complete
// frames (write and read bursts, address wrap, read-after-write) is applied in
// a loop; hand-written sequences cover TX backpressure, frame abort with RX
// flush, and reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_abort = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_empty = 1'b1;
  logic              rx_rd_en;
  logic [7:0]        tx_data;
  logic              tx_wr_en;
  logic              tx_full = 1'b0;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic              bus_re;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata = 8'h00;
  logic              busy;

  spi_reg_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_abort (frame_abort),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_rd_en    (rx_rd_en),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .tx_full     (tx_full),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Environment models: RX FIFO, TX FIFO, register bank, protocol monitors
  // ---------------------------------------------------------------------------
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [14:0] wr_q[$];       // {addr, data} of each bus write
  logic [6:0]  rd_addr_q[$];  // address of each bus read
  logic [7:0]  mem[128];
  logic        prev_rd = 1'b0;
  int          both_err = 0;
  int          full_err = 0;
  int          b2b_err  = 0;
  int          unf_err  = 0;

  always @(posedge clk) begin
    prev_rd <= rx_rd_en;
    if (rx_rd_en) begin
      if (rx_q.size() > 0) rx_data <= rx_q.pop_front();
      else unf_err <= unf_err + 1;
      if (prev_rd) b2b_err <= b2b_err + 1;
    end
    rx_empty <= (rx_q.size() == 0);

    // Register bank: default pattern addr ^ 0x5A, except 0x10 holds 0x3C.
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= (i == 16) ? 8'h3C : (8'(i) ^ 8'h5A);
    end else if (bus_we) begin
      mem[bus_addr] <= bus_wdata;
    end
    if (bus_re) bus_rdata <= mem[bus_addr];

    if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
    if (bus_re) rd_addr_q.push_back(bus_addr);
    if (bus_we && bus_re) both_err <= both_err + 1;
    if (tx_wr_en) begin
      if (tx_full) full_err <= full_err + 1;
      tx_q.push_back(tx_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " rx_rd_en"},  32'(rx_rd_en),  0);
    check({tag, " tx_wr_en"},  32'(tx_wr_en),  0);
    check({tag, " bus_we"},    32'(bus_we),    0);
    check({tag, " bus_re"},    32'(bus_re),    0);
    check({tag, " busy"},      32'(busy),      0);
    check({tag, " bus_addr"},  32'(bus_addr),  0);
    check({tag, " bus_wdata"}, 32'(bus_wdata), 0);
    check({tag, " tx_data"},   32'(tx_data),   0);
  endtask

  // Waits for a frame to start (busy high) and finish (busy low), bounded.
  task automatic wait_frame(output bit ok);
    int t;
    ok = 1'b1;
    t = 0;
    while (!busy && t < 20) begin @(negedge clk); t++; end
    if (!busy) ok = 1'b0;
    t = 0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    if (busy) ok = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Frame table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]      cmd;
    logic [7:0]      len;
    logic [3:0][7:0] wd;   // write data bytes, index 0 first
    int              n;    // transfers = len + 1
    logic [3:0][6:0] ea;   // expected bus addresses
    logic [3:0][7:0] ed;   // expected write data or TX bytes
  } vec_t;

  vec_t vt[8];

  task automatic run_vec(input vec_t v, input int idx);
    bit          ok;
    logic [14:0] e;
    string       p;
    p = $sformatf("v%0d", idx);
    wr_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    rx_q.push_back(v.cmd);
    rx_q.push_back(v.len);
    if (v.cmd[7]) for (int i = 0; i < v.n; i++) rx_q.push_back(v.wd[i]);
    wait_frame(ok);
    check({p, " frame done"}, 32'(ok), 1);
    if (v.cmd[7]) begin
      check({p, " write count"}, wr_q.size(), v.n);
      check({p, " tx count"}, tx_q.size(), 0);
      for (int i = 0; i < wr_q.size() && i < v.n; i++) begin
        e = wr_q[i];
        check($sformatf("%s wr%0d addr", p, i), 32'(e[14:8]), 32'(v.ea[i]));
        check($sformatf("%s wr%0d data", p, i), 32'(e[7:0]),  32'(v.ed[i]));
      end
    end else begin
      check({p, " read count"}, rd_addr_q.size(), v.n);
      check({p, " tx count"}, tx_q.size(), v.n);
      check({p, " write count"}, wr_q.size(), 0);
      for (int i = 0; i < rd_addr_q.size() && i < v.n; i++)
        check($sformatf("%s rd%0d addr", p, i), 32'(rd_addr_q[i]), 32'(v.ea[i]));
      for (int i = 0; i < tx_q.size() && i < v.n; i++)
        check($sformatf("%s tx%0d data", p, i), 32'(tx_q[i]), 32'(v.ed[i]));
    end
    check({p, " rx left"}, rx_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    int t;
    int hits;

    // Writes first; the later reads return what the writes left in the bank.
    vt[0] = '{8'h85, 8'h01, {8'h00, 8'h00, 8'hBB, 8'hAA}, 2,
              {7'h00, 7'h00, 7'h06, 7'h05}, {8'h00, 8'h00, 8'hBB, 8'hAA}};
    vt[1] = '{8'hFF, 8'h01, {8'h00, 8'h00, 8'h22, 8'h11}, 2,
              {7'h00, 7'h00, 7'h00, 7'h7F}, {8'h00, 8'h00, 8'h22, 8'h11}};
    vt[2] = '{8'h81, 8'h00, {8'h00, 8'h00, 8'h00, 8'h5A}, 1,
              {7'h00, 7'h00, 7'h00, 7'h01}, {8'h00, 8'h00, 8'h00, 8'h5A}};
    vt[3] = '{8'hC0, 8'h02, {8'h00, 8'h03, 8'h02, 8'h01}, 3,
              {7'h00, 7'h42, 7'h41, 7'h40}, {8'h00, 8'h03, 8'h02, 8'h01}};
    vt[4] = '{8'h10, 8'h00, 32'h0, 1,
              {7'h00, 7'h00, 7'h00, 7'h10}, {8'h00, 8'h00, 8'h00, 8'h3C}};
    vt[5] = '{8'h7F, 8'h01, 32'h0, 2,
              {7'h00, 7'h00, 7'h00, 7'h7F}, {8'h00, 8'h00, 8'h22, 8'h11}};
    vt[6] = '{8'h05, 8'h01, 32'h0, 2,
              {7'h00, 7'h00, 7'h06, 7'h05}, {8'h00, 8'h00, 8'hBB, 8'hAA}};
    vt[7] = '{8'h01, 8'h02, 32'h0, 3,
              {7'h00, 7'h03, 7'h02, 7'h01}, {8'h00, 8'h59, 8'h58, 8'h5A}};

    // Reset state.
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle");

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // TX backpressure: read 3 bytes from 0x40 while the TX FIFO is full.
    tx_q.delete();
    tx_full = 1'b1;
    rx_q.push_back(8'h40);
    rx_q.push_back(8'h02);
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (tx_wr_en) hits++;
    end
    check("bp no push while full", hits, 0);
    check("bp tx empty while full", tx_q.size(), 0);
    check("bp busy while stalled", 32'(busy), 1);
    tx_full = 1'b0;
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    check("bp frame done", 32'(busy), 0);
    check("bp tx count", tx_q.size(), 3);
    for (int i = 0; i < tx_q.size() && i < 3; i++)
      check($sformatf("bp tx%0d", i), 32'(tx_q[i]), 32'(i + 1));

    // Abort after the first data byte of an L=3 write to 0x10.
    wr_q.delete();
    rx_q.push_back(8'h90);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h33);
    rx_q.push_back(8'h44);
    t = 0;
    while (wr_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
    check("abort first write seen", wr_q.size(), 1);
    frame_abort = 1'b1;
    @(negedge clk);
    check("abort idle next cycle", 32'(busy), 0);
    check("abort bus_we low", 32'(bus_we), 0);
    repeat (20) @(negedge clk);
    check("abort rx flushed", rx_q.size(), 0);
    check("abort rx_empty", 32'(rx_empty), 1);
    frame_abort = 1'b0;
    repeat (10) @(negedge clk);
    check("abort stays idle", 32'(busy), 0);
    check("abort single write", wr_q.size(), 1);
    if (wr_q.size() > 0) check("abort write entry", 32'(wr_q[0]), 32'({7'h10, 8'h11}));

    // Reset while the bridge is in WAIT_RD.
    tx_q.delete();
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h00);
    t = 0;
    while (!bus_re && t < 50) begin @(negedge clk); t++; end
    check("rst bus_re seen", 32'(bus_re), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst mid-read");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst no tx push", tx_q.size(), 0);
    check("rst idle after", 32'(busy), 0);

    // Protocol monitors over the whole run.
    check("bus_we and bus_re together", both_err, 0);
    check("tx push while full", full_err, 0);
    check("back-to-back rx pops", b2b_err, 0);
    check("rx pop while empty", unf_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
